// File: rtl/axi_if.sv
// axi_if: AXI4 bundle between the cache arbiter's out port and the RAM responder
interface axi_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
  logic [ADDR_WIDTH-1:0] araddr, awaddr;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, arready, awvalid, awready;
  logic [DATA_WIDTH-1:0] rdata, wdata;
  logic [1:0] rresp, bresp;
  logic rlast, rvalid, rready;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wlast, wvalid, wready;
  logic bvalid, bready;
  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    output awaddr, awlen, awsize, awburst, awvalid,
    output rready, wdata, wstrb, wlast, wvalid, bready,
    input arready, awready, rdata, rresp, rlast, rvalid, wready, bresp, bvalid
  );
  modport slave (
    input araddr, arlen, arsize, arburst, arvalid,
    input awaddr, awlen, awsize, awburst, awvalid,
    input rready, wdata, wstrb, wlast, wvalid, bready,
    output arready, awready, rdata, rresp, rlast, rvalid, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-transaction AXI4 RAM responder with byte-strobed writes and burst support
module axi_ram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS = 16384,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter INIT_FILE = ""
) (
  input logic clk,
  input logic rst_n,
  axi_if.slave s
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS) << 2;
  typedef enum logic [1:0] {IDLE, RDATA, WDATA, WRESP} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt, rd_addr;
  logic [7:0] len, cnt;
  logic [2:0] size;
  logic [1:0] burst;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, berr;
  logic ar_hs, aw_hs, r_acc, w_acc, w_end, rd_ok, rd_bad;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a - BASE_ADDR} < LIMIT;
  endfunction
  function automatic logic [IW-1:0] widx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction
  always_comb begin
    ar_hs = state == IDLE && s.arvalid;
    aw_hs = state == IDLE && !s.arvalid && s.awvalid;
    r_acc = state == RDATA && s.rready;
    w_acc = state == WDATA && s.wvalid;
    w_end = w_acc && (s.wlast || cnt == len);
    addr_nxt = burst == 2'b00 ? addr : addr + (ADDR_WIDTH'(1) << size);
    rd_addr = ar_hs ? s.araddr : addr_nxt;
    rd_bad = ar_hs ? s.arburst[1] : burst[1];
    rd_ok = in_range(rd_addr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = s.arvalid ? RDATA : s.awvalid ? WDATA : IDLE;
      RDATA: state_nxt = r_acc && rlast ? IDLE : RDATA;
      WDATA: state_nxt = w_end ? WRESP : WDATA;
      WRESP: state_nxt = s.bready ? IDLE : WRESP;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    s.arready = state == IDLE;
    s.awready = state == IDLE && !s.arvalid;
    s.rvalid = state == RDATA;
    s.rdata = rdata;
    s.rresp = rresp;
    s.rlast = rlast;
    s.wready = state == WDATA;
    s.bvalid = state == WRESP;
    s.bresp = state == WRESP && berr ? 2'b10 : 2'b00;
  end
  // The next read beat is fetched on the same edge the current one is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      cnt <= '0;
      rdata <= '0;
      rresp <= '0;
      rlast <= 1'b0;
      berr <= 1'b0;
    end else begin
      if (ar_hs || aw_hs) begin
        addr <= ar_hs ? s.araddr : s.awaddr;
        len <= ar_hs ? s.arlen : s.awlen;
        size <= ar_hs ? s.arsize : s.awsize;
        burst <= ar_hs ? s.arburst : s.awburst;
        cnt <= '0;
        berr <= 1'b0;
      end
      if (ar_hs || (r_acc && !rlast)) begin
        rdata <= rd_ok ? mem[widx(rd_addr)] : '0;
        rresp <= !rd_ok || rd_bad ? 2'b10 : 2'b00;
        rlast <= ar_hs ? s.arlen == 8'd0 : cnt + 8'd1 == len;
      end
      if ((r_acc && !rlast) || w_acc) begin
        addr <= addr_nxt;
        cnt <= cnt + 8'd1;
      end
      if (w_acc) berr <= berr | !in_range(addr) | burst[1] | (s.wlast != (cnt == len));
    end
  always_ff @(posedge clk)
    if (w_acc && in_range(addr))
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (s.wstrb[i]) mem[widx(addr)][8*i +: 8] <= s.wdata[8*i +: 8];
endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: directed plus randomized AXI transactions checked against a word-array model
module tb_axi_ram_slave;
  localparam int MW = 16384;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  axi_if bus ();
  axi_ram_slave #(.MEM_WORDS(MW)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  int total = 0;
  int bad = 0;
  logic [31:0] model [MW];
  logic [31:0] wd [256];
  logic [3:0] ws [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] bu, input logic [2:0] sz);
    return bu == 2'b00 ? a : a + (32'd1 << sz);
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return a >= 32'(MW * 4);
  endfunction

  task automatic rd(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input bit stall);
    int t;
    logic [31:0] ea, ed;
    logic [1:0] er;
    ea = a;
    bus.araddr = a; bus.arlen = len; bus.arsize = sz; bus.arburst = bu; bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_wait", 32'(t < 50), 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      ed = oor(ea) ? 32'd0 : model[ea >> 2];
      er = oor(ea) || bu[1] ? 2'b10 : 2'b00;
      t = 0;
      while (1) begin
        bus.rready = stall && t < 3 ? 1'($urandom_range(0, 1)) : 1'b1;
        chk("rvalid", 32'(bus.rvalid), 1);
        chk("rdata", bus.rdata, ed);
        chk("rresp", 32'(bus.rresp), 32'(er));
        chk("rlast", 32'(bus.rlast), 32'(k == int'(len)));
        chk("awready_busy", 32'(bus.awready), 0);
        @(posedge clk); #1;
        t++;
        if (bus.rready || t >= 20) break;
      end
      ea = step(ea, bu, sz);
    end
    bus.rready = 1'b0;
    chk("rvalid_end", 32'(bus.rvalid), 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu, input int wl);
    int t, n;
    bit err;
    logic [31:0] ea;
    ea = a;
    n = wl < int'(len) ? wl : int'(len);
    err = wl != int'(len) || bu[1];
    bus.awaddr = a; bus.awlen = len; bus.awsize = sz; bus.awburst = bu; bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin @(posedge clk); #1; t++; end
    chk("aw_wait", 32'(t < 50), 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int k = 0; k <= n; k++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[k]; bus.wstrb = ws[k]; bus.wlast = k == wl;
      t = 0;
      while (!bus.wready && t < 20) begin @(posedge clk); #1; t++; end
      chk("wready", 32'(bus.wready), 1);
      @(posedge clk); #1;
      if (oor(ea)) err = 1'b1;
      else for (int i = 0; i < 4; i++) if (ws[k][i]) model[ea >> 2][8*i +: 8] = wd[k][8*i +: 8];
      ea = step(ea, bu, sz);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("wready_after", 32'(bus.wready), 0);
    chk("bvalid", 32'(bus.bvalid), 1);
    chk("bresp", 32'(bus.bresp), err ? 32'd2 : 32'd0);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk("bvalid_end", 32'(bus.bvalid), 0);
  endtask

  initial begin
    logic [7:0] rl;
    logic [1:0] rb;
    logic [2:0] rs;
    logic [31:0] ra;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.rready = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    for (int i = 0; i < MW; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", 32'(bus.arready), 1);
    chk("rst_awready", 32'(bus.awready), 1);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rresp", 32'(bus.rresp), 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_bresp", 32'(bus.bresp), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 192; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    wr(32'h0, 8'd191, 3'd2, 2'b01, 191);
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    wr(32'h10, 8'd0, 3'd2, 2'b01, 0);
    rd(32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
    rd(32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    rd(32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    wd[1] = 32'hAABBCCDD; ws[1] = 4'h3;
    wr(32'h200, 8'd1, 3'd2, 2'b01, 1);
    rd(32'h200, 8'd1, 3'd2, 2'b01, 1'b0);
    wd[0] = 32'h5A5A0001; ws[0] = 4'hF;
    wd[1] = 32'h5A5A0002; ws[1] = 4'hF;
    bus.awaddr = 32'h180; bus.awlen = 8'd1; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.araddr = 32'h40; bus.arlen = 8'd2; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    #1;
    chk("both_awready", 32'(bus.awready), 0);
    chk("both_arready", 32'(bus.arready), 1);
    rd(32'h40, 8'd2, 3'd2, 2'b01, 1'b1);
    wr(32'h180, 8'd1, 3'd2, 2'b01, 1);
    rd(32'h180, 8'd1, 3'd2, 2'b01, 1'b0);
    rd(32'(MW * 4), 8'd0, 3'd2, 2'b01, 1'b0);
    rd(32'(MW * 4) - 32'd4, 8'd1, 3'd2, 2'b01, 1'b0);
    rd(32'h40, 8'd3, 3'd2, 2'b00, 1'b1);
    rd(32'h40, 8'd1, 3'd2, 2'b10, 1'b0);
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    wr(32'h20, 8'd1, 3'd2, 2'b01, 0);
    wr(32'(MW * 4), 8'd0, 3'd2, 2'b01, 0);
    wd[1] = 32'h0BADC0DE; ws[1] = 4'hC;
    wr(32'h30, 8'd1, 3'd2, 2'b01, 5);
    rd(32'h20, 8'd5, 3'd2, 2'b01, 1'b0);
    for (int it = 0; it < 40; it++) begin
      rl = 8'($urandom_range(0, 7));
      rb = $urandom_range(0, 9) == 0 ? 2'b10 : 2'($urandom_range(0, 1));
      rs = 3'($urandom_range(0, 2));
      ra = 32'($urandom_range(0, 180)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom); end
        wr(ra, rl, rs, rb, $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 7)) : int'(rl));
      end else rd(ra, rl, rs, rb, 1'($urandom_range(0, 1)));
    end
    bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arsize = 3'd2; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    chk("mid_beat0", bus.rdata, model[32'h100 >> 2]);
    @(posedge clk); #1;
    chk("mid_beat1", bus.rdata, model[32'h104 >> 2]);
    bus.rready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.rvalid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_arready", 32'(bus.arready), 1);
    rd(32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    rd(32'h0, 8'd191, 3'd2, 2'b01, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
